// File: rtl/mem_sort_if.sv
// Bus bundle between mem_sort_master and its data memory / controlling agent.
// The master modport is the sorter's side of the bus; slave is the memory/processor side.
interface mem_sort_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] swap_count;
   logic [ADDR_W-1:0] mem_read_address;
   logic [ADDR_W-1:0] mem_write_address;
   logic              mem_write_enable;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      input  start, base_addr, mem_data_out,
      output busy, done, swap_count,
             mem_read_address, mem_write_address, mem_write_enable, mem_data_in
   );

   modport slave (
      output start, base_addr, mem_data_out,
      input  busy, done, swap_count,
             mem_read_address, mem_write_address, mem_write_enable, mem_data_in
   );
endinterface

// File: rtl/mem_sort_master.sv
// In-place bubble sort of a length-prefixed word array in data memory, acting as bus master.
// Build option SORT_SIGNED_EN: compare elements as two's-complement instead of unsigned.
module mem_sort_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   mem_sort_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE, LOAD_N, RD_A, RD_B, CMP, WR_A, WR_B, DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] j;
   logic [DATA_W-1:0] limit;
   logic              swapped;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;

   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] swap_q;
   logic [ADDR_W-1:0] raddr_q;
   logic [ADDR_W-1:0] waddr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] j_inc;
   logic [DATA_W-1:0] adv_j;
   logic [DATA_W-1:0] adv_limit;
   logic              pass_end;
   logic              lim_one;

   function automatic logic a_gt_b(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SORT_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Element idx lives one word past the length word.
   function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [DATA_W-1:0] idx);
      return b + ADDR_W'(idx) + ADDR_W'(1);
   endfunction

   assign j_inc     = j + DATA_W'(1);
   assign pass_end  = !(j_inc < limit);
   assign lim_one   = (limit == DATA_W'(1));
   assign adv_j     = pass_end ? '0 : j_inc;
   assign adv_limit = pass_end ? limit - DATA_W'(1) : limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         base    <= '0;
         j       <= '0;
         limit   <= '0;
         swapped <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         swap_q  <= '0;
         raddr_q <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  base    <= bus.base_addr;
                  swap_q  <= '0;
                  raddr_q <= bus.base_addr;
                  busy_q  <= 1'b1;
                  state   <= LOAD_N;
               end
            end
            LOAD_N: begin
               if (bus.mem_data_out <= DATA_W'(1)) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  limit   <= bus.mem_data_out - DATA_W'(1);
                  j       <= '0;
                  swapped <= 1'b0;
                  raddr_q <= elem_addr(base, '0);
                  state   <= RD_A;
               end
            end
            RD_A: begin
               raddr_q <= elem_addr(base, j_inc);
               state   <= RD_B;
            end
            RD_B: state <= CMP;
            CMP: begin
               if (a_gt_b(a_q, b_q)) begin
                  we_q    <= 1'b1;
                  waddr_q <= elem_addr(base, j);
                  wdata_q <= b_q;
                  state   <= WR_A;
               end else if (pass_end && (!swapped || lim_one)) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  j       <= adv_j;
                  limit   <= adv_limit;
                  swapped <= pass_end ? 1'b0 : swapped;
                  raddr_q <= elem_addr(base, adv_j);
                  state   <= RD_A;
               end
            end
            WR_A: begin
               waddr_q <= elem_addr(base, j_inc);
               wdata_q <= a_q;
               state   <= WR_B;
            end
            WR_B: begin
               // This compare swapped, so only the last pass (limit 1) can end the sort here.
               we_q   <= 1'b0;
               swap_q <= swap_q + DATA_W'(1);
               if (pass_end && lim_one) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  j       <= adv_j;
                  limit   <= adv_limit;
                  swapped <= !pass_end;
                  raddr_q <= elem_addr(base, adv_j);
                  state   <= RD_A;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand capture from the combinational read port; pure data, no reset needed.
   always_ff @(posedge clk) begin
      if (state == RD_A) a_q <= bus.mem_data_out;
      if (state == RD_B) b_q <= bus.mem_data_out;
   end

   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.swap_count        = swap_q;
   assign bus.mem_read_address  = raddr_q;
   assign bus.mem_write_address = waddr_q;
   assign bus.mem_write_enable  = we_q;
   assign bus.mem_data_in       = wdata_q;

endmodule

// File: tb/tb_mem_sort_master.sv
// Randomized scoreboard bench for mem_sort_master with a behavioural memory and sort model.
module tb_mem_sort_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] MEMW = 32'd1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_sort_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();
   mem_sort_master #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(mif));

   // Memory: combinational read, clocked write; out-of-range reads 0, writes dropped.
   logic [31:0] mem [0:1023];
   logic        tb_we;
   logic [31:0] tb_wa, tb_wd;
   always @(posedge clk) begin
      if (mif.mem_write_enable) begin
         if (mif.mem_write_address < MEMW) mem[mif.mem_write_address[9:0]] <= mif.mem_data_in;
      end else if (tb_we && tb_wa < MEMW) begin
         mem[tb_wa[9:0]] <= tb_wd;
      end
   end
   assign mif.mem_data_out = (mif.mem_read_address < MEMW) ? mem[mif.mem_read_address[9:0]] : '0;

   typedef struct {
      logic [31:0] base;
      int          n;
      int          swaps;
      int          cycles;
      logic [31:0] sorted [16];
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   runs_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
`ifdef SORT_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Reference: sorted order via queue sort, swaps as the inversion count,
   // cycle cost by replaying bubble-sort passes on a copy (3 per compare, +2 per swap).
   function automatic exp_t build_exp(input logic [31:0] base, input int n, input logic [31:0] v [16]);
      exp_t        e;
      logic [31:0] k[$];
      logic [31:0] w [16];
      logic [31:0] flip;
      logic [31:0] t;
      int          lim;
      bit          sw;
`ifdef SORT_SIGNED_EN
      flip = 32'h8000_0000;
`else
      flip = 32'h0;
`endif
      e.base = base;
      e.n = n;
      e.swaps = 0;
      for (int i = 0; i < 16; i++) e.sorted[i] = 32'h0;
      for (int i = 0; i < n; i++)
         for (int m = i + 1; m < n; m++)
            if (gt(v[i], v[m])) e.swaps++;
      for (int i = 0; i < n; i++) k.push_back(v[i] ^ flip);
      k.sort();
      for (int i = 0; i < n; i++) e.sorted[i] = k[i] ^ flip;
      w = v;
      e.cycles = 1;
      if (n >= 2) begin
         lim = n - 1;
         forever begin
            sw = 0;
            for (int jj = 0; jj < lim; jj++) begin
               if (gt(w[jj], w[jj+1])) begin
                  t = w[jj]; w[jj] = w[jj+1]; w[jj+1] = t;
                  e.cycles += 5;
                  sw = 1;
               end else begin
                  e.cycles += 3;
               end
            end
            if (!sw || lim == 1) break;
            lim--;
         end
      end
      e.cycles += 1;
      return e;
   endfunction

   // Monitor: pops the scoreboard on every done pulse and checks result, latency and writes.
   int   cyc, wcount;
   logic prev_busy, prev_done;
   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
         cyc = 0;
         wcount = 0;
      end else begin
         if (prev_done) begin
            check("done_single_pulse", 32'(mif.done), 32'd0);
            check("busy_after_done", 32'(mif.busy), 32'd0);
         end
         if (mif.busy && !prev_busy) begin
            cyc = 1;
            wcount = 0;
         end else if (mif.busy) begin
            cyc++;
         end
         if (mif.busy && mif.mem_write_enable) wcount++;
         if (mif.done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
               mon_e = sb.pop_front();
               check("done_cycle", 32'(cyc), 32'(mon_e.cycles));
               check("swap_count", mif.swap_count, 32'(mon_e.swaps));
               check("write_cycles", 32'(wcount), 32'(2 * mon_e.swaps));
               check("length_word", mem[mon_e.base[9:0]], 32'(mon_e.n));
               for (int i = 0; i < mon_e.n; i++)
                  check($sformatf("elem[%0d]", i), mem[10'(mon_e.base + 32'(i) + 32'd1)], mon_e.sorted[i]);
            end
            runs_done++;
         end
         prev_busy = mif.busy;
         prev_done = mif.done;
      end
   end

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      tb_wa = a;
      tb_wd = d;
      tb_we = 1'b1;
      @(posedge clk);
      #1 tb_we = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] base);
      mif.base_addr = base;
      mif.start = 1'b1;
      @(posedge clk);
      #1 mif.start = 1'b0;
      mif.base_addr = '0;
   endtask

   task automatic run(input logic [31:0] base, input int n, input logic [31:0] v [16],
                      input bit load, input bit poke_busy);
      int r0;
      if (load) begin
         poke(base, 32'(n));
         for (int i = 0; i < n; i++) poke(base + 32'(i) + 32'd1, v[i]);
      end
      sb.push_back(build_exp(base, n, v));
      r0 = runs_done;
      pulse_start(base);
      if (poke_busy) begin
         repeat (3) @(posedge clk);
         #1 pulse_start(32'h300);
      end
      for (int k = 0; k < 3000 && runs_done == r0; k++) @(posedge clk);
      if (runs_done == r0) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout: got no done within 3000 cycles, expected done");
         sb.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(mif.busy), 32'd0);
      check({tag, "_done"}, 32'(mif.done), 32'd0);
      check({tag, "_we"}, 32'(mif.mem_write_enable), 32'd0);
      check({tag, "_raddr"}, mif.mem_read_address, 32'd0);
      check({tag, "_waddr"}, mif.mem_write_address, 32'd0);
      check({tag, "_wdata"}, mif.mem_data_in, 32'd0);
      check({tag, "_swaps"}, mif.swap_count, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v [16];
      int          n;
      logic [31:0] b;
      rst = 1'b0;
      tb_we = 1'b0;
      tb_wa = '0;
      tb_wd = '0;
      mif.start = 1'b0;
      mif.base_addr = '0;
      #3 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      v = '{default: 32'h0};
      v[0] = 32'd33; v[1] = 32'd1;
      run(32'h0, 2, v, 1, 0);

      v = '{default: 32'h0};
      v[0] = 5; v[1] = 4; v[2] = 3; v[3] = 2; v[4] = 1;
      run(32'h100, 5, v, 1, 0);

      v = '{default: 32'h0};
      v[0] = 1; v[1] = 2; v[2] = 3; v[3] = 3;
      run(32'h20, 4, v, 1, 0);

      v = '{default: 32'h0};
      run(32'h30, 0, v, 1, 0);
      v[0] = 32'hdead;
      run(32'h38, 1, v, 1, 0);

      v = '{default: 32'h0};
      v[0] = 32'hFFFF_FFFF; v[1] = 32'd5;
      run(32'h50, 2, v, 1, 0);

      for (int r = 0; r < 12; r++) begin
         n = (r == 5) ? 6 : int'($urandom_range(2, 9));
         b = 32'($urandom_range(64, 900));
         v = '{default: 32'h0};
         for (int i = 0; i < n; i++)
            v[i] = (r % 3 == 0) ? $urandom() : 32'($urandom_range(0, 15));
         run(b, n, v, 1, r == 5);
      end

      // Abort during WR_B of the first swap, then rerun on whatever memory holds.
      v = '{default: 32'h0};
      v[0] = 9; v[1] = 3; v[2] = 7;
      poke(32'h40, 32'd3);
      for (int i = 0; i < 3; i++) poke(32'h41 + 32'(i), v[i]);
      pulse_start(32'h40);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mif.mem_write_enable) break;
      end
      @(negedge clk);
      check("wr_b_we_high", 32'(mif.mem_write_enable), 32'd1);
      rst = 1'b1;
      #1 check_reset_outputs("abort");
      @(posedge clk);
      #1;
      check("abort_mem1", mem[10'h41], 32'd3);
      check("abort_mem2", mem[10'h42], 32'd3);
      check("abort_mem3", mem[10'h43], 32'd7);
      rst = 1'b0;
      @(posedge clk);
      #1;
      v = '{default: 32'h0};
      for (int i = 0; i < 3; i++) v[i] = mem[10'h41 + 10'(i)];
      run(32'h40, 3, v, 0, 0);

      repeat (5) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_sort_master.md
# mem_sort_master

Memory-side initiator that sorts a length-prefixed word array in data memory in place with bubble sort. It drives the data memory's read address, write address, write enable and write data, and consumes its combinational read data. A processor or testbench triggers it with `start`. It sits beside the core as a bus master on the data memory port, and the core must not touch that port while `busy` is high.

## Interface
- `ADDR_W`, 32, width of memory addresses and of `base_addr`
- `DATA_W`, 32, width of memory words; also the width of the length word and of `swap_count`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `base_addr`  in  ADDR_W  address of the length word N; the array occupies `base_addr+1` to `base_addr+N`
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  single-cycle pulse when the sort completes
- `swap_count`  out  DATA_W  number of swaps performed in the current or last run
- `mem_read_address`  out  ADDR_W  to memory read address
- `mem_write_address`  out  ADDR_W  to memory write address
- `mem_write_enable`  out  1  to memory write enable
- `mem_data_in`  out  DATA_W  write data to memory
- `mem_data_out`  in  DATA_W  combinational read data from memory, valid in the same cycle as `mem_read_address`

## Operation
- States: IDLE, LOAD_N, RD_A, RD_B, CMP, WR_A, WR_B, DONE.
- IDLE:
  - When `start`=1: latch `base_addr` into `base`, clear `swap_count`, go to LOAD_N.
  - `start` is ignored in all other states.
- LOAD_N:
  - `mem_read_address`=base; capture N.
  - If N≤1: go to DONE with no writes.
  - Otherwise: limit=N-1, j=0, swapped=0, go to RD_A.
- RD_A: read base+1+j, capture A, go to RD_B.
- RD_B: read base+2+j, capture B, go to CMP.
- CMP: if A>B go to WR_A; otherwise advance.
- WR_A: write B to base+1+j.
- WR_B: write A to base+2+j; set swapped=1; `swap_count`+=1; advance.
- Advance rule:
  - If j+1<limit: j+=1, go to RD_A.
  - Else (end of pass): if swapped=0 or limit=1, go to DONE; otherwise limit-=1, j=0, swapped=0, go to RD_A.
- DONE: `done`=1 for one cycle, go to IDLE.
- Arithmetic:
  - Address math is ADDR_W-bit modulo 2^ADDR_W; wrap-around is not detected.
  - Out-of-range addresses follow memory semantics: reads return 0 and writes are dropped.
  - N is unsigned DATA_W; j and limit are DATA_W wide.
- Stable outputs:
  - `mem_write_enable`, `mem_write_address`, `mem_data_in` and `mem_read_address` are driven from flops and never glitch, because the memory write is level-sensitive.
  - Write address and write data are valid the whole cycle `mem_write_enable` is high.

## Timing
- Reset values:
  - state=IDLE.
  - `busy`=0, `done`=0, `mem_write_enable`=0.
  - All address and data outputs =0; `swap_count`=0.
- Write timing: `mem_write_enable` is high only during WR_A and WR_B, one cycle each.
- Cycle costs:
  - A non-swapping compare costs 3 cycles (RD_A, RD_B, CMP).
  - A swapping compare costs 5 cycles.
- Latency from the accepting edge:
  - LOAD_N is cycle 1.
  - For N≤1, `done` is high in cycle 2.
- `swap_count` holds its value after DONE until the next accepted `start`.
- Reset mid-operation aborts immediately:
  - `mem_write_enable` drops asynchronously.
  - Memory keeps whatever writes already completed, including a half-done swap after WR_A.
- The memory contents are owned by this block while `busy`=1; outside writers during that window give undefined results.

## Configuration
- `SORT_SIGNED_EN` defined: CMP compares A and B as two's-complement signed values.
- `SORT_SIGNED_EN` undefined (default): CMP compares A and B as unsigned values.
- The macro changes nothing else: FSM, timing and reset are identical in both builds.

## Test plan
- Base=0, mem[0]=2, mem[1]=33, mem[2]=1, pulse `start` -> mem[1]=1, mem[2]=33; `swap_count`=1; `done` high exactly 7 cycles after the accepting edge, as a single pulse.
- Base=0x100, N=5, array [5,4,3,2,1] -> [1,2,3,4,5]; `swap_count`=10; exactly 20 write-enable cycles.
- N=4, array already sorted [1,2,3,3] -> no write-enable cycles; `swap_count`=0; `done` after one pass (LOAD_N + 9 compare cycles). N=0 and N=1 -> `done` in cycle 2 with no writes.
- N=2, array [0xFFFFFFFF, 5]: without `SORT_SIGNED_EN` -> [5, 0xFFFFFFFF], `swap_count`=1. With `SORT_SIGNED_EN` -> unchanged, `swap_count`=0.
- Assert `rst` during WR_B of the first swap -> all outputs at reset values immediately; a fresh `start` then completes the sort correctly. `start` pulsed while `busy` -> ignored, and the run is unaffected.
